// File: rtl/encrypt_feed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : encrypt_feed
// Purpose  : Front-end sequencer for the LWE encryption accumulator. Picks a
//            random subset of the BIG_N public-key samples, then streams the
//            public-key matrix column by column (two samples per cycle) from
//            an external synchronous memory. Unselected samples are zeroed,
//            and the scaled plaintext is added to the first b-column word.
// Ports    : clk, rst_n (async, active-low)
//            start, plaintext            - request / message
//            pk_ren, pk_addr             - pair read port, 1-cycle latency
//            pk_rdata0, pk_rdata1        - samples 2*pair and 2*pair+1
//            op1, op2, row, en           - accumulator operand stream
//            done (1-cycle pulse), busy  - status
// Config   : ENCRYPT_FEED_SELECT_INPUT_EN - when defined, the selection mask
//            comes from input sel_mask_in (captured with start) and the
//            LFSR-driven SELECT phase is removed.
// Revision : 1.0 - initial release
// ============================================================================
module encrypt_feed #(
  parameter int          PLAINTEXT_WIDTH  = 6,
  parameter int          CIPHERTEXT_WIDTH = 10,
  parameter int          DIMENSION        = 10,
  parameter int          DIM_WIDTH        = 4,
  parameter int          BIG_N            = 30,
  parameter int          PK_ADDR_WIDTH    = 8,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
`ifdef ENCRYPT_FEED_SELECT_INPUT_EN
  input  logic [BIG_N-1:0]            sel_mask_in,
`endif
  output logic                        pk_ren,
  output logic [PK_ADDR_WIDTH-1:0]    pk_addr,
  input  logic [CIPHERTEXT_WIDTH-1:0] pk_rdata0,
  input  logic [CIPHERTEXT_WIDTH-1:0] pk_rdata1,
  output logic [CIPHERTEXT_WIDTH-1:0] op1,
  output logic [CIPHERTEXT_WIDTH-1:0] op2,
  output logic [DIM_WIDTH-1:0]        row,
  output logic                        en,
  output logic                        done,
  output logic                        busy
);

  localparam int c_PAIRS     = BIG_N / 2;
  localparam int c_PAIR_W    = (c_PAIRS > 1) ? $clog2(c_PAIRS) : 1;
  localparam int c_MSG_SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_FETCH  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [BIG_N-1:0]            r_sel_mask;
  logic [PLAINTEXT_WIDTH-1:0]  r_plaintext;
  logic [c_PAIR_W-1:0]         r_pair;
  logic [DIM_WIDTH-1:0]        r_col;
  logic [PK_ADDR_WIDTH-1:0]    r_addr;
  // Read-side pipeline: tags travelling alongside the memory latency
  logic                        r_rd_v;
  logic                        r_rd_last;
  logic [c_PAIR_W-1:0]         r_rd_pair;
  logic [DIM_WIDTH-1:0]        r_rd_col;
  logic                        r_out_last;
  logic [CIPHERTEXT_WIDTH-1:0] r_op1, r_op2;
  logic [DIM_WIDTH-1:0]        r_row;
  logic                        r_en, r_done;

`ifndef ENCRYPT_FEED_SELECT_INPUT_EN
  localparam int c_K_W = $clog2(BIG_N);
  logic [15:0]     r_lfsr;
  logic [c_K_W-1:0] r_k;
  logic            w_fb;
  // Fibonacci taps x^16+x^14+x^13+x^11+1 for a right-shifting register
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
`endif

  logic                        w_last_pair, w_last_col, w_last_read;
  logic [c_PAIR_W:0]           w_idx0, w_idx1;
  logic                        w_inject;
  logic [CIPHERTEXT_WIDTH-1:0] w_msg, w_op1, w_op2;

  assign w_last_pair = (r_pair == c_PAIR_W'(c_PAIRS - 1));
  assign w_last_col  = (r_col == DIM_WIDTH'(DIMENSION));
  assign w_last_read = (r_state == S_FETCH) && w_last_pair && w_last_col;

  assign w_idx0   = {r_rd_pair, 1'b0};
  assign w_idx1   = {r_rd_pair, 1'b1};
  assign w_inject = (r_rd_col == DIM_WIDTH'(DIMENSION)) && (r_rd_pair == '0);
  assign w_msg    = CIPHERTEXT_WIDTH'(r_plaintext) << c_MSG_SHIFT;
  // Adding in CIPHERTEXT_WIDTH bits gives the modular wrap for free
  assign w_op1    = (r_sel_mask[w_idx0] ? pk_rdata0 : '0) + (w_inject ? w_msg : '0);
  assign w_op2    =  r_sel_mask[w_idx1] ? pk_rdata1 : '0;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ENCRYPT_FEED_SELECT_INPUT_EN
          w_next = S_FETCH;
`else
          w_next = S_SELECT;
`endif
        end
      end
`ifndef ENCRYPT_FEED_SELECT_INPUT_EN
      S_SELECT: if (r_k == c_K_W'(BIG_N - 1)) w_next = S_FETCH;
`endif
      S_FETCH:  if (w_last_read) w_next = S_DRAIN;
      // Stay until the final word has left the output stage
      S_DRAIN:  if (r_out_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel_mask  <= '0;
      r_plaintext <= '0;
      r_pair      <= '0;
      r_col       <= '0;
      r_addr      <= '0;
      r_rd_v      <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_pair   <= '0;
      r_rd_col    <= '0;
      r_out_last  <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_row       <= '0;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
`ifndef ENCRYPT_FEED_SELECT_INPUT_EN
      r_lfsr      <= LFSR_SEED;
      r_k         <= '0;
`endif
    end else begin
      r_state <= w_next;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_plaintext <= plaintext;
            r_pair      <= '0;
            r_col       <= '0;
            r_addr      <= '0;
`ifdef ENCRYPT_FEED_SELECT_INPUT_EN
            r_sel_mask  <= sel_mask_in;
`else
            r_k         <= '0;
`endif
          end
        end
`ifndef ENCRYPT_FEED_SELECT_INPUT_EN
        S_SELECT: begin
          r_sel_mask[r_k] <= r_lfsr[0];
          r_lfsr          <= {w_fb, r_lfsr[15:1]};
          r_k             <= r_k + c_K_W'(1);
        end
`endif
        S_FETCH: begin
          // Pair index runs fastest, column slowest
          if (w_last_pair) begin
            r_pair <= '0;
            r_col  <= w_last_col ? '0 : r_col + DIM_WIDTH'(1);
          end else begin
            r_pair <= r_pair + c_PAIR_W'(1);
          end
          r_addr <= w_last_read ? '0 : r_addr + PK_ADDR_WIDTH'(1);
        end
        default: ;
      endcase

      r_rd_v     <= (r_state == S_FETCH);
      r_rd_last  <= w_last_read;
      r_rd_pair  <= r_pair;
      r_rd_col   <= r_col;
      r_out_last <= r_rd_v && r_rd_last;

      // Output stage: one cycle behind the read that produced the data
      r_en <= r_rd_v;
      if (r_rd_v) begin
        r_op1 <= w_op1;
        r_op2 <= w_op2;
        r_row <= r_rd_col;
      end else begin
        r_op1 <= '0;
        r_op2 <= '0;
        if (r_out_last) r_row <= '0;
      end
      r_done <= r_out_last;
    end
  end

  assign pk_ren  = (r_state == S_FETCH);
  assign pk_addr = r_addr;
  assign op1     = r_op1;
  assign op2     = r_op2;
  assign row     = r_row;
  assign en      = r_en;
  assign done    = r_done;
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_encrypt_feed.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_encrypt_feed
// Purpose  : Scoreboard bench for encrypt_feed. A driver issues encryptions
//            and pushes the expected operand stream (and done time) computed
//            from a behavioural model; a monitor pops and compares whenever
//            the DUT asserts en or done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encrypt_feed;

  localparam int PW = 6, CW = 10, DIM = 10, DW = 4, N = 30, AW = 8;
  localparam int NP = N / 2;
  localparam int R  = (DIM + 1) * NP;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef ENCRYPT_FEED_SELECT_INPUT_EN
  localparam int SEL_LAT = 0;
`else
  localparam int SEL_LAT = N;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] plaintext = '0;
  logic [N-1:0]  sel_mask_in = '0;
  logic          pk_ren;
  logic [AW-1:0] pk_addr;
  logic [CW-1:0] pk_rdata0 = '0, pk_rdata1 = '0;
  logic [CW-1:0] op1, op2;
  logic [DW-1:0] row;
  logic          en, done, busy;

  encrypt_feed dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .plaintext (plaintext),
`ifdef ENCRYPT_FEED_SELECT_INPUT_EN
    .sel_mask_in(sel_mask_in),
`endif
    .pk_ren    (pk_ren),
    .pk_addr   (pk_addr),
    .pk_rdata0 (pk_rdata0),
    .pk_rdata1 (pk_rdata1),
    .op1       (op1),
    .op2       (op2),
    .row       (row),
    .en        (en),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Public-key memory: synchronous read, one pair per address
  logic [CW-1:0] mem0 [R];
  logic [CW-1:0] mem1 [R];
  always @(posedge clk) begin
    if (pk_ren && int'(pk_addr) < R) begin
      pk_rdata0 <= mem0[pk_addr];
      pk_rdata1 <= mem1[pk_addr];
    end
  end

  typedef struct {
    int op1;
    int op2;
    int row;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   dq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int unsigned m_lfsr = SEED;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  always begin
    exp_t e;
    int   d;
    @(posedge clk);
    cyc++;
    #1;
    if (en) begin
      if (q.size() == 0) begin
        chk("unexpected_en", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("op1", 32'(op1), 32'(e.op1));
        chk("op2", 32'(op2), 32'(e.op2));
        chk("row", 32'(row), 32'(e.row));
        chk("en_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_during_en", 32'(busy), 32'd1);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        d = dq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d));
        chk("stream_complete_at_done", 32'(q.size()), 32'd0);
        chk("row_at_done", 32'(row), 32'd0);
        chk("en_low_at_done", 32'(en), 32'd0);
      end
    end
  end

  task automatic fill(input bit pattern);
    for (int a = 0; a < R; a++) begin
      if (pattern) begin
        mem0[a] = CW'(2 * a);
        mem1[a] = CW'(2 * a + 1);
      end else begin
        mem0[a] = CW'($urandom);
        mem1[a] = CW'($urandom);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pk_ren"},  32'(pk_ren),  32'd0);
    chk({tag, "_pk_addr"}, 32'(pk_addr), 32'd0);
    chk({tag, "_op1"},     32'(op1),     32'd0);
    chk({tag, "_op2"},     32'(op2),     32'd0);
    chk({tag, "_row"},     32'(row),     32'd0);
    chk({tag, "_en"},      32'(en),      32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
  endtask

  // mode 0: plain; 1: extra start at read 40; 2: reset at read 50
  task automatic run(input logic [PW-1:0] pt, input logic [N-1:0] mask_in, input int mode);
    logic [N-1:0] mask;
    int t, budget;
    int v1, v2, col, p;
    exp_t e;
`ifdef ENCRYPT_FEED_SELECT_INPUT_EN
    mask = mask_in;
`else
    for (int k = 0; k < N; k++) begin
      int unsigned fb;
      mask[k] = m_lfsr[0];
      fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << 15);
    end
`endif
    @(negedge clk);
    start = 1'b1;
    plaintext = pt;
    sel_mask_in = mask_in;
    t = cyc + 1;
    for (int i = 0; i < R; i++) begin
      col = i / NP;
      p   = i % NP;
      v1  = mask[2*p]   ? int'(mem0[i]) : 0;
      v2  = mask[2*p+1] ? int'(mem1[i]) : 0;
      if (col == DIM && p == 0) v1 = (v1 + int'(pt) * (1 << (CW - PW))) % (1 << CW);
      e.op1 = v1; e.op2 = v2; e.row = col; e.cyc = t + SEL_LAT + 2 + i;
      q.push_back(e);
    end
    dq.push_back(t + SEL_LAT + R + 2);
    @(negedge clk);
    start = 1'b0;
    plaintext = ~pt;
    sel_mask_in = ~mask_in;

    if (mode == 1) begin
      while (cyc < t + SEL_LAT + 40) @(negedge clk);
      start = 1'b1;
      plaintext = pt ^ 6'h2A;
      sel_mask_in = '1;
      @(negedge clk);
      start = 1'b0;
    end else if (mode == 2) begin
      while (cyc < t + SEL_LAT + 50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_mid_fetch");
      q.delete();
      dq.delete();
      m_lfsr = SEED;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      return;
    end

    budget = SEL_LAT + R + 50;
    while (dq.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (dq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: done not seen, %0d words still pending", q.size());
      q.delete();
      dq.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fill(1'b0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef ENCRYPT_FEED_SELECT_INPUT_EN
    fill(1'b1);
    run(6'd0, '1, 0);                 // select all, no message
    fill(1'b0);
    run(6'd1, '0, 0);                 // select none, message only
    fill(1'b0);
    mem0[DIM*NP] = 10'd1023;
    run(6'd63, N'($urandom) | N'(1), 0);  // message wrap
`else
    fill(1'b0);
    mem0[DIM*NP] = 10'd1023;
    run(6'd63, '0, 0);                // seed bit0 = 1 selects sample 0: wrap
    fill(1'b1);
    run(PW'($urandom), '0, 0);        // LFSR continues, new mask
`endif
    fill(1'b0);
    run(PW'($urandom), N'($urandom), 1);  // start while busy ignored
    run(PW'($urandom), N'($urandom), 2);  // reset mid-fetch
    fill(1'b0);
    run(PW'($urandom), N'($urandom), 0);  // full stream after reset
    for (int n = 0; n < 3; n++) begin
      fill(1'b0);
      run(PW'($urandom), N'($urandom), 0);
    end

    chk("leftover_words", 32'(q.size()), 32'd0);
    chk("leftover_done", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
